// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer for the 5-stage core
// Covers memory wait, MDU occupancy, branch squash and load-use, plus a stall-cycle counter.
module hazard_ctrl #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_mdu,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mdu_start,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CB = $clog2(MDU_LATENCY) + 1;

  typedef enum logic [1:0] {RUN, MDU_BUSY, MDU_DONE, MEM_WAIT} state_t;

  state_t        state, state_nx, ret_state, ret_nx;
  logic [CB-1:0] cnt, cnt_nx;

  logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_flush_c;
  logic ex_mem_stall_c, ex_mem_flush_c, mem_wb_flush_c, mdu_start_c;
  logic load_use, mem_wait;

  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == id_ex_rd)));
  assign mem_wait = dmem_req && !dmem_ready;

  always_comb begin
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    ex_mem_flush_c = 1'b0;
    mem_wb_flush_c = 1'b0;
    mdu_start_c    = 1'b0;
    state_nx       = state;
    ret_nx         = ret_state;
    cnt_nx         = cnt;

    if ((state == MEM_WAIT && !dmem_ready) || (state != MEM_WAIT && mem_wait)) begin
      // Freeze everything up to MEM; MEM/WB gets a bubble while the access is pending.
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      mem_wb_flush_c = 1'b1;
      if (state != MEM_WAIT) begin
        state_nx = MEM_WAIT;
        ret_nx   = state;
      end
    end else if (state == MEM_WAIT) begin
      state_nx = ret_state;
    end else begin
      case (state)
        RUN: begin
          if (id_ex_mdu) begin
            mdu_start_c    = 1'b1;
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_flush_c = 1'b1;
            cnt_nx         = CB'(MDU_LATENCY - 2);
            state_nx       = (MDU_LATENCY == 2) ? MDU_DONE : MDU_BUSY;
          end else if (ex_branch_taken) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (load_use) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end
        end
        MDU_BUSY: begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_stall_c  = 1'b1;
          ex_mem_flush_c = 1'b1;
          cnt_nx         = cnt - CB'(1);
          if (cnt == CB'(1)) state_nx = MDU_DONE;
        end
        MDU_DONE: begin
          // The finishing MDU op advances; id_ex_mdu is deliberately ignored here.
          if (ex_branch_taken) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end
          state_nx = RUN;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  assign pc_stall     = !rst && pc_stall_c;
  assign if_id_stall  = !rst && if_id_stall_c;
  assign if_id_flush  = !rst && if_id_flush_c;
  assign id_ex_stall  = !rst && id_ex_stall_c;
  assign id_ex_flush  = !rst && id_ex_flush_c;
  assign ex_mem_stall = !rst && ex_mem_stall_c;
  assign ex_mem_flush = !rst && ex_mem_flush_c;
  assign mem_wb_flush = !rst && mem_wb_flush_c;
  assign mdu_start    = !rst && mdu_start_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      ret_state    <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
      cnt       <= cnt_nx;
      if (pc_stall_c && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
// Control outputs are packed into one vector and compared against hand-built patterns.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_mdu;
  logic       ex_branch_taken, dmem_req, dmem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, ex_mem_flush, mem_wb_flush, mdu_start;
  logic [3:0] stall_cycles;
  logic [8:0] ctl;

  int passed = 0;
  int total  = 0;

  // {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_f, mdu_start}
  localparam logic [8:0] NONE  = 9'b000000000;
  localparam logic [8:0] MEMW  = 9'b110101010;
  localparam logic [8:0] MENT  = 9'b110100101;
  localparam logic [8:0] MBSY  = 9'b110100100;
  localparam logic [8:0] BR    = 9'b001010000;
  localparam logic [8:0] LU    = 9'b110010000;

  hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .id_ex_mdu(id_ex_mdu),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .mdu_start(mdu_start),
    .stall_cycles(stall_cycles)
  );

  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, ex_mem_flush, mem_wb_flush, mdu_start};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ex_mem_read = 1'b0;
    id_ex_mdu = 1'b0; ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // Entered and left at posedge+1: check the combinational controls, then clock.
  task automatic cyc(input string tag, input logic [8:0] exp);
    #2;
    chk(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #2;
    chk("reset_ctl", 32'(ctl), 32'(NONE));
    chk("reset_cnt", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load-use on rs1: one stall, then the bubble in EX clears it.
    cyc("lu_rs1", LU);
    id_ex_mem_read = 1'b0;
    cyc("lu_after", NONE);
    chk("lu_cnt", 32'(stall_cycles), 32'd1);
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    cyc("lu_rs2", LU);
    id_uses_rs2 = 1'b0;
    cyc("lu_rs2_unused", NONE);
    id_ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    cyc("lu_x0", NONE);
    id_ex_rd = 5'd9; id_rs1 = 5'd9; ex_branch_taken = 1'b1;
    cyc("branch_over_lu", BR);
    chk("branch_cnt", 32'(stall_cycles), 32'd2);

    // MDU occupancy: 3 stalled cycles then MDU_DONE.
    do_reset();
    id_ex_mdu = 1'b1;
    cyc("mdu_c0", MENT);
    cyc("mdu_c1", MBSY);
    cyc("mdu_c2", MBSY);
    cyc("mdu_done", NONE);
    id_ex_mdu = 1'b0;
    cyc("mdu_after", NONE);
    chk("mdu_cnt", 32'(stall_cycles), 32'd3);

    // Memory wait inside MDU_BUSY with cnt=2 freezes the countdown.
    do_reset();
    id_ex_mdu = 1'b1;
    cyc("mw_mdu_c0", MENT);
    dmem_req = 1'b1; dmem_ready = 1'b0;
    cyc("mw_detect", MEMW);
    cyc("mw_wait", MEMW);
    dmem_ready = 1'b1;
    cyc("mw_exit", NONE);
    dmem_req = 1'b0;
    cyc("mw_resume1", MBSY);
    cyc("mw_resume2", MBSY);
    cyc("mw_done", NONE);
    id_ex_mdu = 1'b0;
    chk("mw_cnt", 32'(stall_cycles), 32'd5);

    // Memory wait from RUN beats a pending MDU, which then enters after the exit.
    do_reset();
    id_ex_mdu = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    cyc("mw_run_detect", MEMW);
    dmem_ready = 1'b1;
    cyc("mw_run_exit", NONE);
    dmem_req = 1'b0;
    cyc("mw_run_mdu_entry", MENT);
    id_ex_mdu = 1'b0;

    // Asynchronous reset between edges while in MDU_BUSY.
    do_reset();
    id_ex_mdu = 1'b1;
    cyc("ar_c0", MENT);
    #2;
    chk("ar_busy", 32'(ctl), 32'(MBSY));
    #1 rst = 1'b1;
    #1;
    chk("ar_ctl_now", 32'(ctl), 32'(NONE));
    chk("ar_cnt_now", 32'(stall_cycles), 32'd0);
    id_ex_mdu = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_cnt_edge", 32'(stall_cycles), 32'd0);
    cyc("ar_quiet", NONE);
    id_ex_mdu = 1'b1;
    cyc("ar_run_entry", MENT);
    id_ex_mdu = 1'b0;

    // Saturation: a held load-use gives 17 stall cycles on a 4-bit counter.
    do_reset();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd4; id_rs1 = 5'd4; id_uses_rs1 = 1'b1;
    for (int i = 0; i < 17; i++) cyc("sat_lu", LU);
    chk("sat_cnt", 32'(stall_cycles), 32'd15);
    clear_inputs();
    cyc("sat_idle", NONE);
    chk("sat_hold", 32'(stall_cycles), 32'd15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Generates per-stage stall (hold) and flush (bubble) controls for:
  - load-use hazards that forwarding cannot cover;
  - multi-cycle mul/div occupancy of EX;
  - data-memory wait states;
  - taken-branch squashes.
- Sits beside the forwarding logic and drives the enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps a stall-cycle performance counter.

Parameters:
- MDU_LATENCY, 4, total cycles an MDU instruction occupies EX; legal range >= 2.
- CNT_W, 32, width of the stall_cycles counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_rs1  in  5  source register 1 of instruction in ID
- id_rs2  in  5  source register 2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_ex_rd  in  5  destination register of instruction in EX
- id_ex_mem_read  in  1  EX instruction is a load
- id_ex_mdu  in  1  EX instruction is mul/div
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- dmem_req  in  1  MEM stage is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  clear IF/ID to a NOP
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  clear ID/EX to a NOP
- ex_mem_stall  out  1  hold EX/MEM
- ex_mem_flush  out  1  load a bubble into EX/MEM
- mem_wb_flush  out  1  load a bubble into MEM/WB
- mdu_start  out  1  one-cycle start pulse to the MDU
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Reset:
  - Asynchronous; state=RUN, ret_state=RUN, cnt=0, stall_cycles=0.
  - All control outputs are 0 while rst=1.
  - Reset mid-operation abandons MDU/MEM sequences and asserts no pulses.
- Registered state: RUN, MDU_BUSY, MDU_DONE, MEM_WAIT; plus ret_state, cnt, stall_cycles.
- All control outputs are combinational from state and inputs.
- Priority within a cycle: memory wait > MDU > branch flush > load-use.
- Memory wait:
  - Condition: dmem_req=1 and dmem_ready=0, in any state other than MEM_WAIT.
  - On detection: next state=MEM_WAIT, ret_state=current state.
  - Outputs this cycle and every MEM_WAIT cycle: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush = 1; all other outputs 0.
  - cnt is frozen; mdu_start is suppressed; ex_branch_taken is ignored.
  - Exit: in MEM_WAIT with dmem_ready=1, no stalls are asserted and MEM/WB accepts the result.
  - Next state = ret_state, except ret_state=RUN with id_ex_mdu=1 is treated as MDU entry in the following cycle.
- MDU entry (RUN, id_ex_mdu=1, no memory wait):
  - mdu_start=1; pc_stall, if_id_stall, id_ex_stall, ex_mem_flush = 1.
  - cnt <= MDU_LATENCY-2.
  - Next state: MDU_DONE if MDU_LATENCY==2, else MDU_BUSY.
- MDU_BUSY:
  - Same stall/flush set as MDU entry, with mdu_start=0.
  - cnt decrements each cycle; when cnt==1, next state is MDU_DONE.
- MDU_DONE:
  - No stalls; EX result advances.
  - id_ex_mdu is not re-evaluated (no re-trigger).
  - Next state: RUN.
- MDU occupancy: EX is occupied exactly MDU_LATENCY cycles, with stalls on the first MDU_LATENCY-1 of them.
- Branch (RUN or MDU_DONE, ex_branch_taken=1):
  - if_id_flush=1 and id_ex_flush=1.
  - No stall; suppresses load-use for that cycle.
- Load-use (RUN only):
  - Condition: id_ex_mem_read=1, id_ex_rd != 0, and (id_uses_rs1 and id_rs1==id_ex_rd) or (id_uses_rs2 and id_rs2==id_ex_rd).
  - Outputs: pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle.
  - No state change; the next cycle re-evaluates with the bubble in EX.
- Stall flag semantics: a stall flag holds its register; a flush flag clears it. The two are never both 1 for the same register.
- stall_cycles: +1 on every clk edge with pc_stall=1; saturates at all-ones and does not wrap.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle of pc_stall=if_id_stall=id_ex_flush=1, then 0. With id_ex_rd=0 instead → no stall.
- MDU, MDU_LATENCY=4: id_ex_mdu=1 held → mdu_start pulses in cycle 0 only; stalls in cycles 0–2; cycle 3 is MDU_DONE with no stall; stall_cycles +3.
- Memory wait mid-MDU: dmem_ready=0 for 2 cycles during MDU_BUSY with cnt=2 → MEM_WAIT for 2 cycles with cnt frozen, then resume; total MDU stall cycles = 3+2.
- Branch vs load-use: load-use condition and ex_branch_taken=1 in the same cycle → if_id_flush=id_ex_flush=1, pc_stall=0.
- Async reset: rst pulse inside MDU_BUSY, between clock edges → all outputs 0 immediately; state=RUN and stall_cycles=0 at the next edge; no spurious mdu_start.
- Saturation: preload stall_cycles to 2^CNT_W-1 (or use CNT_W=4, count 15), assert a further stall → value stays at 15.
